// File: rtl/first_nios2_system_keys_pio_pkg.sv
// Shared constants for the keys input PIO: register map and edge-type encodings.
package first_nios2_system_keys_pio_pkg;

  // Word addresses on the 2-bit slave address bus
  localparam logic [1:0] ADDR_DATA         = 2'd0;
  localparam logic [1:0] ADDR_IRQ_MASK     = 2'd2;
  localparam logic [1:0] ADDR_EDGE_CAPTURE = 2'd3;

  // Edge selection for the capture logic
  localparam int unsigned EDGE_RISE = 0;
  localparam int unsigned EDGE_FALL = 1;
  localparam int unsigned EDGE_ANY  = 2;

endpackage

// File: rtl/pio_sync_edge.sv
// Two-flop input synchroniser plus previous-value register and per-bit edge select.
module pio_sync_edge
  import first_nios2_system_keys_pio_pkg::*;
#(
  parameter int unsigned      WIDTH      = 4,
  parameter int unsigned      EDGE_TYPE  = EDGE_FALL,
  parameter logic [WIDTH-1:0] IDLE_LEVEL = '1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] in_port,
  output logic [WIDTH-1:0] sync2,
  output logic [WIDTH-1:0] edge_det
);

  logic [WIDTH-1:0] sync1_q;
  logic [WIDTH-1:0] sync2_q;
  logic [WIDTH-1:0] prev_q;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;

  // Resynchronise inputs; reset to the idle level so no edge appears after reset
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= IDLE_LEVEL;
      sync2_q <= IDLE_LEVEL;
      prev_q  <= IDLE_LEVEL;
    end else begin
      sync1_q <= in_port;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  // Select the configured edge polarity from the synchronised value and its predecessor
  always_comb begin
    rise = sync2_q & ~prev_q;
    fall = ~sync2_q & prev_q;
    if (EDGE_TYPE == EDGE_RISE) begin
      edge_det = rise;
    end else if (EDGE_TYPE == EDGE_FALL) begin
      edge_det = fall;
    end else begin
      edge_det = rise | fall;
    end
  end

  assign sync2 = sync2_q;

endmodule

// File: rtl/first_nios2_system_keys_pio.sv
// Avalon-MM input PIO for push-buttons/switches: synchronised data, sticky edge capture
// with write-1-to-clear, interrupt mask and a level interrupt.
module first_nios2_system_keys_pio
  import first_nios2_system_keys_pio_pkg::*;
#(
  parameter int unsigned      WIDTH      = 4,
  parameter int unsigned      EDGE_TYPE  = EDGE_FALL,
  parameter logic [WIDTH-1:0] IDLE_LEVEL = '1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);

  logic [WIDTH-1:0] sync2;
  logic [WIDTH-1:0] edge_det;
  logic [WIDTH-1:0] irq_mask_q;
  logic [WIDTH-1:0] irq_mask_d;
  logic [WIDTH-1:0] edge_capture_q;
  logic [WIDTH-1:0] edge_capture_d;
  logic [WIDTH-1:0] clr;
  logic [31:0]      readdata_q;
  logic [31:0]      readdata_d;
  logic [31:0]      rd_mux;
  logic             wr_en;

  pio_sync_edge #(
    .WIDTH      (WIDTH),
    .EDGE_TYPE  (EDGE_TYPE),
    .IDLE_LEVEL (IDLE_LEVEL)
  ) u_sync_edge (
    .clk      (clk),
    .reset_n  (reset_n),
    .in_port  (in_port),
    .sync2    (sync2),
    .edge_det (edge_det)
  );

  // Upper write-data bits carry nothing for narrow configurations
  if (WIDTH < 32) begin : g_unused_wdata
    logic unused_wdata;
    assign unused_wdata = ^writedata[31:WIDTH];
  end

  assign wr_en = chipselect & ~write_n;

  // Next-state for mask and capture; a new edge beats a simultaneous clear
  always_comb begin
    irq_mask_d = irq_mask_q;
    clr        = '0;
    if (wr_en && (address == ADDR_IRQ_MASK)) begin
      irq_mask_d = writedata[WIDTH-1:0];
    end
    if (wr_en && (address == ADDR_EDGE_CAPTURE)) begin
      clr = writedata[WIDTH-1:0];
    end
    edge_capture_d = edge_det | (edge_capture_q & ~clr);
  end

  // Read mux, zero-extended; unselected cycles return zero
  always_comb begin
    rd_mux = '0;
    unique case (address)
      ADDR_DATA:         rd_mux[WIDTH-1:0] = sync2;
      ADDR_IRQ_MASK:     rd_mux[WIDTH-1:0] = irq_mask_q;
      ADDR_EDGE_CAPTURE: rd_mux[WIDTH-1:0] = edge_capture_q;
      default:           rd_mux = '0;
    endcase
    readdata_d = chipselect ? rd_mux : 32'h0;
  end

  // Register file and registered read data
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irq_mask_q     <= '0;
      edge_capture_q <= '0;
      readdata_q     <= '0;
    end else begin
      irq_mask_q     <= irq_mask_d;
      edge_capture_q <= edge_capture_d;
      readdata_q     <= readdata_d;
    end
  end

  assign readdata = readdata_q;
  assign irq      = |(edge_capture_q & irq_mask_q);

endmodule

// File: tb/tb_first_nios2_system_keys_pio.sv
// Self-checking bench for the keys input PIO; bus reads go through an expected-value queue.
module tb_first_nios2_system_keys_pio;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [3:0]  in_port;
  logic        irq;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  logic [31:0] exp_q[$];
  string       tag_q[$];

  first_nios2_system_keys_pio dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .in_port    (in_port),
    .irq        (irq)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Advance to just after the next rising edge
  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    chipselect = 1'b1;
    write_n    = 1'b0;
    address    = a;
    writedata  = d;
    tick();
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
  endtask

  // Issue a read, queue its expected value, pop and compare when readdata is valid
  task automatic bus_read(input string tag, input logic [1:0] a, input logic [31:0] exp);
    logic [31:0] e;
    string       t;
    chipselect = 1'b1;
    write_n    = 1'b1;
    address    = a;
    exp_q.push_back(exp);
    tag_q.push_back(tag);
    tick();
    chipselect = 1'b0;
    if (exp_q.size() == 0) begin
      check_eq({tag, "_sb_empty"}, 32'h1, 32'h0);
    end else begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      check_eq(t, readdata, e);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n    = 1'b0;
    address    = '0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
    in_port    = 4'hF;

    // 1: reset and idle
    tick(2);
    reset_n = 1'b1;
    tick(10);
    check_eq("idle_readdata", readdata, 32'h0);
    check_eq("idle_irq", {31'h0, irq}, 32'h0);
    bus_read("idle_ec", ADDR_EC(), 32'h0);
    bus_read("idle_data", 2'd0, 32'h0000000F);
    bus_read("idle_rsvd", 2'd1, 32'h0);
    bus_read("idle_mask", 2'd2, 32'h0);
    tick();
    check_eq("unsel_readdata", readdata, 32'h0);

    // 2: falling edge on bit 0 with mask 1
    bus_write(2'd2, 32'h1);
    in_port = 4'hE;
    tick(2);
    check_eq("irq_t2", {31'h0, irq}, 32'h0);
    tick();
    check_eq("irq_t3", {31'h0, irq}, 32'h1);
    bus_read("ec_bit0", ADDR_EC(), 32'h1);
    bus_read("data_e", 2'd0, 32'hE);

    // 3: writing zero leaves state, writing one clears
    bus_write(ADDR_EC(), 32'h0);
    check_eq("irq_wr0", {31'h0, irq}, 32'h1);
    bus_read("ec_wr0", ADDR_EC(), 32'h1);
    bus_write(ADDR_EC(), 32'h1);
    check_eq("irq_clr", {31'h0, irq}, 32'h0);
    bus_read("ec_clr", ADDR_EC(), 32'h0);

    // 4: capture beats simultaneous clear on bit 2
    in_port = 4'hA;
    tick(3);
    bus_read("ec_bit2", ADDR_EC(), 32'h4);
    in_port = 4'hE;
    tick(3);
    bus_read("ec_rise_ignored", ADDR_EC(), 32'h4);
    in_port = 4'hA;
    tick(2);
    bus_write(ADDR_EC(), 32'h4);
    bus_read("ec_cap_wins", ADDR_EC(), 32'h4);

    // 5: mask gating
    in_port = 4'h8;
    tick(3);
    bus_write(2'd2, 32'h0);
    check_eq("irq_mask0", {31'h0, irq}, 32'h0);
    bus_read("ec_six", ADDR_EC(), 32'h6);
    bus_write(2'd2, 32'hFFFF_FFF4);
    check_eq("irq_mask4", {31'h0, irq}, 32'h1);
    bus_read("mask_rd", 2'd2, 32'h4);
    bus_write(2'd2, 32'h1);
    check_eq("irq_mask1", {31'h0, irq}, 32'h0);

    // 6: asynchronous reset with everything pending
    in_port = 4'hF;
    tick(3);
    in_port = 4'h0;
    tick(3);
    bus_write(2'd2, 32'hF);
    check_eq("irq_pre_rst", {31'h0, irq}, 32'h1);
    bus_read("ec_all", ADDR_EC(), 32'hF);
    #2;
    reset_n = 1'b0;
    #1;
    check_eq("irq_async_rst", {31'h0, irq}, 32'h0);
    check_eq("rd_async_rst", readdata, 32'h0);
    in_port = 4'hF;
    tick(2);
    reset_n = 1'b1;
    tick();
    bus_write(2'd0, 32'h5);
    bus_write(2'd1, 32'hF);
    bus_read("post_ec", ADDR_EC(), 32'h0);
    bus_read("post_mask", 2'd2, 32'h0);
    bus_read("post_data", 2'd0, 32'hF);
    bus_read("post_rsvd", 2'd1, 32'h0);
    check_eq("post_irq", {31'h0, irq}, 32'h0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  function automatic logic [1:0] ADDR_EC();
    return 2'd3;
  endfunction

endmodule
